// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: write-back queue issuing up to two regfile writes per cycle with forwarding lookup
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    parameter int SELW  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [SELW-1:0]              req_sel,
    input  logic [WIDTH-1:0]             req_data,
    input  logic                         wb_stall,
    output logic                         in1_we,
    output logic [SELW-1:0]              in1_sel,
    output logic [WIDTH-1:0]             in1_data,
    output logic                         in2_we,
    output logic [SELW-1:0]              in2_sel,
    output logic [WIDTH-1:0]             in2_data,
    input  logic [SELW-1:0]              fwd_sel,
    output logic                         fwd_hit,
    output logic [WIDTH-1:0]             fwd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [SELW-1:0]  sel_q  [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d, nxt;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push;

    // issue decision for the two oldest entries, pointer and occupancy next-state
    always_comb begin
        nxt       = rd_q + PW'(1);
        req_ready = cnt_q < CW'(DEPTH);
        push      = req_valid && req_ready;
        in1_we    = (cnt_q != '0) && !wb_stall;
        in2_we    = (cnt_q >= CW'(2)) && !wb_stall && (sel_q[nxt] != sel_q[rd_q]);
        in1_sel   = in1_we ? sel_q[rd_q]  : '0;
        in1_data  = in1_we ? data_q[rd_q] : '0;
        in2_sel   = in2_we ? sel_q[nxt]   : '0;
        in2_data  = in2_we ? data_q[nxt]  : '0;
        rd_d      = rd_q + PW'(in1_we) + PW'(in2_we);
        wr_d      = wr_q + PW'(push);
        cnt_d     = cnt_q + CW'(push) - CW'(in1_we) - CW'(in2_we);
        count     = cnt_q;
    end

    // forwarding: walk oldest to newest so the newest matching entry wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt_q && sel_q[rd_q + PW'(i)] == fwd_sel) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[rd_q + PW'(i)];
            end
        end
    end

    // pointers and occupancy; reset discards any pending entries
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // entry storage needs no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            sel_q[wr_q]  <= req_sel;
            data_q[wr_q] <= req_data;
        end
    end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: randomized and directed checks of regfile_wb_queue against a queue model
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;
    localparam int WIDTH = 16;
    localparam int SELW  = 4;

    typedef struct packed {
        logic [SELW-1:0]  sel;
        logic [WIDTH-1:0] data;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [SELW-1:0]  req_sel = '0;
    logic [WIDTH-1:0] req_data = '0;
    logic             wb_stall = 1'b0;
    logic             in1_we, in2_we, fwd_hit;
    logic [SELW-1:0]  in1_sel, in2_sel;
    logic [WIDTH-1:0] in1_data, in2_data, fwd_data;
    logic [SELW-1:0]  fwd_sel = '0;
    logic [2:0]       count;

    ent_t             q[$];
    ent_t             exp_log[$];
    ent_t             dut_log[$];
    logic [WIDTH-1:0] rf_dut [16];
    int               n_vec = 0;
    int               n_err = 0;

    regfile_wb_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_data(req_data), .wb_stall(wb_stall),
        .in1_we(in1_we), .in1_sel(in1_sel), .in1_data(in1_data),
        .in2_we(in2_we), .in2_sel(in2_sel), .in2_data(in2_data),
        .fwd_sel(fwd_sel), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
    );

    always #5 clk = ~clk;

    // regfile as seen by the DUT's write ports, plus the order of writes
    always @(posedge clk) begin
        if (!rst) begin
            if (in1_we) begin
                dut_log.push_back('{sel: in1_sel, data: in1_data});
                rf_dut[in1_sel] <= in1_data;
            end
            if (in2_we) begin
                dut_log.push_back('{sel: in2_sel, data: in2_data});
                rf_dut[in2_sel] <= in2_data;
            end
        end
    end

    function automatic logic [62:0] dut_vec();
        return {req_ready, in1_we, in1_sel, in1_data, in2_we, in2_sel, in2_data, fwd_hit, fwd_data, count};
    endfunction

    function automatic logic [62:0] m_exp();
        ent_t e1 = '0;
        ent_t e2 = '0;
        bit w1, w2, h;
        logic [WIDTH-1:0] fd = '0;
        h  = 1'b0;
        w1 = !wb_stall && q.size() >= 1;
        w2 = w1 && q.size() >= 2 && q[1].sel != q[0].sel;
        if (w1) e1 = q[0];
        if (w2) e2 = q[1];
        foreach (q[i]) if (q[i].sel == fwd_sel) begin
            h  = 1'b1;
            fd = q[i].data;
        end
        return {q.size() < DEPTH, w1, e1, w2, e2, h, fd, 3'(q.size())};
    endfunction

    task automatic drive(input bit v, input logic [SELW-1:0] s, input logic [WIDTH-1:0] d,
                         input bit st, input logic [SELW-1:0] fs);
        req_valid = v;
        req_sel   = s;
        req_data  = d;
        wb_stall  = st;
        fwd_sel   = fs;
        #1;
    endtask

    task automatic tick();
        bit p1, p2, pu;
        p1 = !wb_stall && q.size() >= 1;
        p2 = p1 && q.size() >= 2 && q[1].sel != q[0].sel;
        pu = req_valid && q.size() < DEPTH && !rst;
        if (rst) q.delete();
        else begin
            if (p1) exp_log.push_back(q.pop_front());
            if (p2) exp_log.push_back(q.pop_front());
            if (pu) q.push_back('{sel: req_sel, data: req_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 5, 16'h1234, 0, 5);
        tick();
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 5);
        n_vec++;
        if (dut_vec() !== {1'b1, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0, 16'h0, 3'd0}) begin
            n_err++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec(), {1'b1, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0, 16'h0, 3'd0});
        end
    endtask

    task automatic test_single();
        drive(1, 1, 16'hDEAD, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        n_vec++;
        if ({in1_we, in1_sel, in1_data, in2_we} !== {1'b1, 4'd1, 16'hDEAD, 1'b0}) begin
            n_err++;
            $display("FAIL single_issue got=%h exp=%h", {in1_we, in1_sel, in1_data, in2_we}, {1'b1, 4'd1, 16'hDEAD, 1'b0});
        end
        tick();
        n_vec++;
        if (count !== 3'd0) begin
            n_err++;
            $display("FAIL single_drain count got=%0d exp=0", count);
        end
    endtask

    task automatic test_dual_issue();
        logic [SELW-1:0]  s5 [5] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
        logic [WIDTH-1:0] d5 [5] = '{16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678, 16'h9999};
        for (int k = 0; k < 5; k++) begin
            drive(1, s5[k], d5[k], 1, 0);
            if (k == 4) begin
                n_vec++;
                if ({count, req_ready} !== {3'd4, 1'b0}) begin
                    n_err++;
                    $display("FAIL full count/ready got=%0d/%0d exp=4/0", count, req_ready);
                end
            end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        n_vec++;
        if ({in1_we, in1_sel, in1_data, in2_we, in2_sel, in2_data} !== {1'b1, 4'd1, 16'hDEAD, 1'b1, 4'd2, 16'hBEEF}) begin
            n_err++;
            $display("FAIL dual_A got=%h exp=%h", {in1_we, in1_sel, in1_data, in2_we, in2_sel, in2_data},
                     {1'b1, 4'd1, 16'hDEAD, 1'b1, 4'd2, 16'hBEEF});
        end
        tick();
        n_vec++;
        if ({in1_we, in1_sel, in1_data, in2_we, in2_sel, in2_data} !== {1'b1, 4'd4, 16'h1234, 1'b1, 4'd5, 16'h5678}) begin
            n_err++;
            $display("FAIL dual_B got=%h exp=%h", {in1_we, in1_sel, in1_data, in2_we, in2_sel, in2_data},
                     {1'b1, 4'd4, 16'h1234, 1'b1, 4'd5, 16'h5678});
        end
        tick();
        n_vec++;
        if (count !== 3'd0) begin
            n_err++;
            $display("FAIL dual_drain count got=%0d exp=0", count);
        end
    endtask

    task automatic test_same_sel();
        drive(1, 3, 16'hAAAA, 1, 0);
        tick();
        drive(1, 3, 16'hBBBB, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        n_vec++;
        if ({in1_we, in1_sel, in1_data, in2_we} !== {1'b1, 4'd3, 16'hAAAA, 1'b0}) begin
            n_err++;
            $display("FAIL same_sel_A got=%h exp=%h", {in1_we, in1_sel, in1_data, in2_we}, {1'b1, 4'd3, 16'hAAAA, 1'b0});
        end
        tick();
        n_vec++;
        if ({in1_we, in1_sel, in1_data} !== {1'b1, 4'd3, 16'hBBBB}) begin
            n_err++;
            $display("FAIL same_sel_B got=%h exp=%h", {in1_we, in1_sel, in1_data}, {1'b1, 4'd3, 16'hBBBB});
        end
        tick();
        n_vec++;
        if (rf_dut[3] !== 16'hBBBB) begin
            n_err++;
            $display("FAIL same_sel_rf r3 got=%h exp=bbbb", rf_dut[3]);
        end
    endtask

    task automatic test_forward();
        drive(1, 7, 16'h1111, 1, 0);
        tick();
        drive(1, 7, 16'h2222, 1, 0);
        tick();
        drive(0, 0, 0, 1, 7);
        n_vec++;
        if ({fwd_hit, fwd_data} !== {1'b1, 16'h2222}) begin
            n_err++;
            $display("FAIL fwd_hit7 got=%h exp=12222", {fwd_hit, fwd_data});
        end
        drive(0, 0, 0, 1, 8);
        n_vec++;
        if ({fwd_hit, fwd_data} !== {1'b1 ^ 1'b1, 16'h0}) begin
            n_err++;
            $display("FAIL fwd_miss8 got=%h exp=00000", {fwd_hit, fwd_data});
        end
        drive(1, 9, 16'h4321, 1, 9);
        n_vec++;
        if (fwd_hit !== 1'b0) begin
            n_err++;
            $display("FAIL fwd_incoming got=%b exp=0", fwd_hit);
        end
        drive(0, 0, 0, 0, 7);
        n_vec++;
        if ({in1_we, fwd_hit, fwd_data} !== {1'b1, 1'b1, 16'h2222}) begin
            n_err++;
            $display("FAIL fwd_issuing got=%h exp=%h", {in1_we, fwd_hit, fwd_data}, {1'b1, 1'b1, 16'h2222});
        end
        tick();
        tick();
        n_vec++;
        if (count !== 3'd0) begin
            n_err++;
            $display("FAIL fwd_drain count got=%0d exp=0", count);
        end
    endtask

    task automatic test_reset_flush();
        int lsz;
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'(10 + k), 16'(16'hC000 + k), 1, 0);
            tick();
        end
        rst = 1'b1;
        drive(1, 13, 16'hCCCC, 1, 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 1, 0);
        n_vec++;
        if ({count, req_ready} !== {3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL flush count/ready got=%0d/%0d exp=0/1", count, req_ready);
        end
        lsz = dut_log.size();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0);
            n_vec++;
            if ({in1_we, in2_we} !== 2'b00) begin
                n_err++;
                $display("FAIL flush_we cycle %0d got=%b exp=00", k, {in1_we, in2_we});
            end
            tick();
        end
        n_vec++;
        if (dut_log.size() !== lsz) begin
            n_err++;
            $display("FAIL flush_writes got=%0d exp=%0d", dut_log.size(), lsz);
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] wd [12];
        int idx = 0;
        int lsz;
        bit acc;
        foreach (wd[i]) wd[i] = 16'($urandom);
        lsz = dut_log.size();
        for (int c = 0; c < 300 && (idx < 12 || q.size() > 0); c++) begin
            drive(idx < 12, 4'(idx), idx < 12 ? wd[idx] : 16'h0, 1'($urandom % 2), 0);
            n_vec++;
            if (dut_vec() !== m_exp()) begin
                n_err++;
                $display("FAIL wrap cycle %0d got=%h exp=%h", c, dut_vec(), m_exp());
            end
            acc = idx < 12 && q.size() < DEPTH;
            tick();
            if (acc) idx++;
        end
        n_vec++;
        if (idx != 12 || q.size() != 0) begin
            n_err++;
            $display("FAIL wrap_timeout pushed=%0d left=%0d exp=12/0", idx, q.size());
        end
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (rf_dut[i] !== wd[i] || dut_log.size() < lsz + 12 || dut_log[lsz + i] !== ent_t'({4'(i), wd[i]})) begin
                n_err++;
                $display("FAIL wrap_order r%0d got=%h exp=%h", i, rf_dut[i], wd[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom % 50) == 0;
            drive(($urandom % 3) != 0, 4'($urandom % 6), 16'($urandom), ($urandom % 3) == 0, 4'($urandom % 6));
            n_vec++;
            if (dut_vec() !== m_exp()) begin
                n_err++;
                $display("FAIL random cycle %0d got=%h exp=%h", c, dut_vec(), m_exp());
            end
            tick();
        end
        rst = 1'b0;
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            drive(0, 0, 0, 0, 0);
            tick();
        end
        n_vec++;
        if (count !== 3'd0 || q.size() != 0) begin
            n_err++;
            $display("FAIL random_drain count got=%0d exp=0", count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_issue();
        test_same_sel();
        test_forward();
        test_reset_flush();
        test_wrap();
        test_random();
        n_vec++;
        if (dut_log.size() != exp_log.size()) begin
            n_err++;
            $display("FAIL write_log size got=%0d exp=%0d", dut_log.size(), exp_log.size());
        end else begin
            foreach (exp_log[i]) begin
                n_vec++;
                if (dut_log[i] !== exp_log[i]) begin
                    n_err++;
                    $display("FAIL write_log[%0d] got=%h exp=%h", i, dut_log[i], exp_log[i]);
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_wb_queue.md
REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

Interface
REQ-001 Parameters SHALL be, one per line:
- DEPTH, 4, number of queue entries (power of two, >= 2)
- WIDTH, 16, data width
- SELW, 4, register select width
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  1  write request present
- req_ready  output  1  queue can accept a request this cycle
- req_sel  input  SELW  destination register
- req_data  input  WIDTH  write data
- wb_stall  input  1  suppresses issue to regfile this cycle
- in1_we  output  1  regfile write port 1 enable (older entry)
- in1_sel  output  SELW  regfile write port 1 select
- in1_data  output  WIDTH  regfile write port 1 data
- in2_we  output  1  regfile write port 2 enable (next-older entry)
- in2_sel  output  SELW  regfile write port 2 select
- in2_data  output  WIDTH  regfile write port 2 data
- fwd_sel  input  SELW  forwarding lookup register
- fwd_hit  output  1  a queued entry targets fwd_sel
- fwd_data  output  WIDTH  data of newest queued entry matching fwd_sel
- count  output  clog2(DEPTH+1)  number of queued entries
REQ-003 Clock SHALL be clk and reset SHALL be rst: one clock, synchronous, active-high reset.

Function
REQ-004 Queue SHALL be a circular FIFO of (sel, data) entries; read/write pointers SHALL wrap modulo DEPTH.
REQ-005 req_ready SHALL equal (count < DEPTH), registered-state only, no combinational path from wb_stall or req_valid.
REQ-006 A request SHALL be enqueued at a rising edge iff req_valid && req_ready && !rst.
REQ-007 in1_we SHALL be (count >= 1) && !wb_stall; in1_sel/in1_data SHALL be the head entry when in1_we=1, else 0.
REQ-008 in2_we SHALL be (count >= 2) && !wb_stall && (sel of entry head+1 != sel of head); in2_sel/in2_data SHALL be entry head+1 when in2_we=1, else 0.
REQ-009 Pops per edge SHALL equal in1_we + in2_we; the regfile consumes the write at the same edge, so latency enqueue-to-regfile-write is exactly 1 edge with no stall.
REQ-010 Same-select adjacent entries SHALL be issued on consecutive cycles via in1 only, preserving program order.
REQ-011 count_next SHALL equal count + push - pops; simultaneous push and pop at full SHALL not occur (req_ready=0 at full).
REQ-012 fwd_hit SHALL be combinational: 1 iff any queued entry has sel == fwd_sel; fwd_data SHALL be the newest such entry's data, else 0.
REQ-013 Entries issued at the current edge SHALL still count for fwd_hit during that cycle; an incoming unaccepted req SHALL not.
REQ-014 wb_stall=1 SHALL hold all queue contents and drive in1_we=in2_we=0; enqueue continues while not full.

Reset
REQ-015 On rst=1 at a rising edge: count=0, both pointers=0, pending entries discarded and never written.
REQ-016 After reset: req_ready=1, in1_we=in2_we=0, in*_sel/in*_data=0, fwd_hit=0, fwd_data=0.
REQ-017 rst SHALL override a simultaneous req_valid: no enqueue on the reset edge.

Verification
REQ-018 Reset, push (1,DEAD) -> next cycle in1_we=1 in1_sel=1 in1_data=DEAD in2_we=0; count 0 after following edge.
REQ-019 wb_stall=1, push (1,DEAD),(2,BEEF),(4,1234),(5,5678), 5th push (6,9999) -> count=4, req_ready=0, 5th not accepted; release stall -> cycle A in1=(1,DEAD) in2=(2,BEEF), cycle B in1=(4,1234) in2=(5,5678), then count=0.
REQ-020 Stall, push (3,AAAA),(3,BBBB), release -> cycle A in1=(3,AAAA) in2_we=0; cycle B in1=(3,BBBB); regfile r3 ends BBBB.
REQ-021 Stall, push (7,1111),(7,2222); fwd_sel=7 -> fwd_hit=1 fwd_data=2222; fwd_sel=8 -> fwd_hit=0 fwd_data=0.
REQ-022 Stall, queue 3 entries, rst for one edge with req_valid=1 -> count=0, req_ready=1, no we asserted for those entries after stall release.
REQ-023 wb_stall toggling pseudo-randomly, 12 sequential pushes to regs 0..11 -> pointers wrap, every write reaches regfile exactly once in order, final regfile matches pushed data.
